// File: rtl/arc4_seq.sv
// ARC4 top-level sequencer: runs init, ksa and prga sub-blocks in turn and arbitrates the shared S memory.
// Optional macro ARC4_SEQ_CYCLE_CNT_EN adds a saturating 'cycles' run-length output.
module arc4_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic        init_en,
    output logic        ksa_en,
    output logic        prga_en,
    input  logic        init_rdy,
    input  logic        ksa_rdy,
    input  logic        prga_rdy,
    output logic [23:0] key_q,
    input  logic [7:0]  init_s_addr,
    input  logic [7:0]  init_s_wrdata,
    input  logic        init_s_wren,
    input  logic [7:0]  ksa_s_addr,
    input  logic [7:0]  ksa_s_wrdata,
    input  logic        ksa_s_wren,
    input  logic [7:0]  prga_s_addr,
    input  logic [7:0]  prga_s_wrdata,
    input  logic        prga_s_wren,
    output logic [7:0]  s_addr,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
`ifdef ARC4_SEQ_CYCLE_CNT_EN
    output logic [31:0] cycles,
`endif
    output logic [1:0]  phase
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_INIT = 3'd1,
        WAIT_INIT  = 3'd2,
        START_KSA  = 3'd3,
        WAIT_KSA   = 3'd4,
        START_PRGA = 3'd5,
        WAIT_PRGA  = 3'd6,
        DONE       = 3'd7
    } state_t;

    state_t state;
    logic   seen_busy;

    // Start pulses are loaded on the edge entering START_x, so a ready sub-block costs one START cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdy       <= 1'b1;
            init_en   <= 1'b0;
            ksa_en    <= 1'b0;
            prga_en   <= 1'b0;
            phase     <= 2'b00;
            key_q     <= 24'h0;
            seen_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state   <= START_INIT;
                        rdy     <= 1'b0;
                        key_q   <= key;
                        phase   <= 2'b01;
                        init_en <= init_rdy;
                    end
                end
                START_INIT: begin
                    if (init_en) begin
                        init_en <= 1'b0;
                        state   <= WAIT_INIT;
                    end else begin
                        init_en <= init_rdy;
                    end
                end
                WAIT_INIT: begin
                    if (init_rdy && seen_busy) begin
                        seen_busy <= 1'b0;
                        state     <= START_KSA;
                        phase     <= 2'b10;
                        ksa_en    <= ksa_rdy;
                    end else if (!init_rdy) begin
                        seen_busy <= 1'b1;
                    end
                end
                START_KSA: begin
                    if (ksa_en) begin
                        ksa_en <= 1'b0;
                        state  <= WAIT_KSA;
                    end else begin
                        ksa_en <= ksa_rdy;
                    end
                end
                WAIT_KSA: begin
                    if (ksa_rdy && seen_busy) begin
                        seen_busy <= 1'b0;
                        state     <= START_PRGA;
                        phase     <= 2'b11;
                        prga_en   <= prga_rdy;
                    end else if (!ksa_rdy) begin
                        seen_busy <= 1'b1;
                    end
                end
                START_PRGA: begin
                    if (prga_en) begin
                        prga_en <= 1'b0;
                        state   <= WAIT_PRGA;
                    end else begin
                        prga_en <= prga_rdy;
                    end
                end
                WAIT_PRGA: begin
                    if (prga_rdy && seen_busy) begin
                        seen_busy <= 1'b0;
                        state     <= DONE;
                        phase     <= 2'b00;
                    end else if (!prga_rdy) begin
                        seen_busy <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    rdy       <= 1'b1;
                    init_en   <= 1'b0;
                    ksa_en    <= 1'b0;
                    prga_en   <= 1'b0;
                    phase     <= 2'b00;
                    seen_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARC4_SEQ_CYCLE_CNT_EN
    // Acceptance edge counts as 1; the edge leaving DONE is not counted, so the value equals run length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles <= 32'h0;
        end else if (state == IDLE) begin
            if (en) begin
                cycles <= 32'd1;
            end
        end else if (state != DONE && cycles != 32'hFFFF_FFFF) begin
            cycles <= cycles + 32'd1;
        end
    end
`endif

    always_comb begin
        s_addr   = 8'h00;
        s_wrdata = 8'h00;
        s_wren   = 1'b0;
        case (phase)
            2'b01: begin
                s_addr   = init_s_addr;
                s_wrdata = init_s_wrdata;
                s_wren   = init_s_wren;
            end
            2'b10: begin
                s_addr   = ksa_s_addr;
                s_wrdata = ksa_s_wrdata;
                s_wren   = ksa_s_wren;
            end
            2'b11: begin
                s_addr   = prga_s_addr;
                s_wrdata = prga_s_wrdata;
                s_wren   = prga_s_wren;
            end
            default: begin
                s_addr   = 8'h00;
                s_wrdata = 8'h00;
                s_wren   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_arc4_seq.sv
// Scoreboard bench for arc4_seq with busy-counter sub-block stubs.
// Define ARC4_SEQ_CYCLE_CNT_EN to also check the cycles output.
module tb_arc4_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic        init_en, ksa_en, prga_en;
    logic        init_rdy, ksa_rdy, prga_rdy;
    logic        ksa_rdy_raw;
    logic [23:0] key_q;
    logic [7:0]  init_s_addr, init_s_wrdata, ksa_s_addr, ksa_s_wrdata, prga_s_addr, prga_s_wrdata;
    logic        init_s_wren, ksa_s_wren, prga_s_wren;
    logic [7:0]  s_addr, s_wrdata;
    logic        s_wren;
    logic [1:0]  phase;
`ifdef ARC4_SEQ_CYCLE_CNT_EN
    logic [31:0] cycles;
`endif

    always #5 clk = ~clk;

    arc4_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .rdy(rdy),
        .key(key),
        .init_en(init_en),
        .ksa_en(ksa_en),
        .prga_en(prga_en),
        .init_rdy(init_rdy),
        .ksa_rdy(ksa_rdy),
        .prga_rdy(prga_rdy),
        .key_q(key_q),
        .init_s_addr(init_s_addr),
        .init_s_wrdata(init_s_wrdata),
        .init_s_wren(init_s_wren),
        .ksa_s_addr(ksa_s_addr),
        .ksa_s_wrdata(ksa_s_wrdata),
        .ksa_s_wren(ksa_s_wren),
        .prga_s_addr(prga_s_addr),
        .prga_s_wrdata(prga_s_wrdata),
        .prga_s_wren(prga_s_wren),
        .s_addr(s_addr),
        .s_wrdata(s_wrdata),
        .s_wren(s_wren),
`ifdef ARC4_SEQ_CYCLE_CNT_EN
        .cycles(cycles),
`endif
        .phase(phase)
    );

    // Stub busy N: N clock periods between the edge sampling x_en and the edge that sees x_rdy high again.
    int busy_i = 4, busy_k = 4, busy_p = 4;
    int late_i = 0;
    int cnt_i = 0, cnt_k = 0, cnt_p = 0;
    logic ksa_hold = 1'b0;

    always @(posedge clk) begin
        if (init_en) cnt_i <= busy_i; else if (cnt_i > 0) cnt_i <= cnt_i - 1;
        if (ksa_en)  cnt_k <= busy_k; else if (cnt_k > 0) cnt_k <= cnt_k - 1;
        if (prga_en) cnt_p <= busy_p; else if (cnt_p > 0) cnt_p <= cnt_p - 1;
    end

    always_comb begin
        init_rdy    = (cnt_i <= 1) || (cnt_i > busy_i - late_i);
        ksa_rdy_raw = (cnt_k <= 1);
        ksa_rdy     = ksa_rdy_raw && !ksa_hold;
        prga_rdy    = (cnt_p <= 1);
    end

    typedef struct {
        logic [2:0]  vec;
        int          offset;
        logic [1:0]  ph;
        string       name;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic prev_rdy = 1'b1;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic pushEvent(input logic [2:0] vec, input int off, input logic [1:0] ph, input string name);
        exp_t e;
        if (off >= 0) begin
            e.vec = vec;
            e.offset = off;
            e.ph = ph;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    // Offsets are in cycles after the acceptance edge; a negative offset means the event must not occur.
    task automatic pushRun(input int oi, input int ok, input int op, input int ordy);
        pushEvent(3'b100, oi, 2'b01, "init_en");
        pushEvent(3'b010, ok, 2'b10, "ksa_en");
        pushEvent(3'b001, op, 2'b11, "prga_en");
        pushEvent(3'b000, ordy, 2'b00, "rdy_return");
    endtask

    // Called at #1 after a rising edge while rdy=1; returns #1 after the acceptance edge.
    task automatic applyStimulus(input logic [23:0] k, input int n1, input int n2, input int n3,
                                 input int oi, input int ok, input int op, input int ordy);
        busy_i = n1;
        busy_k = n2;
        busy_p = n3;
        pushRun(oi, ok, op, ordy);
        key = k;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        key = 24'h0;
    endtask

    task automatic handleEvent(input logic [2:0] vec, input string what);
        exp_t e;
        int off;
        off = cyc - acc_cyc;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_%s: got vector %b at offset %0d, expected no event", what, vec, off);
        end else begin
            e = sb.pop_front();
            checkOutput({e.name, "_which"}, 32'(vec), 32'(e.vec));
            checkOutput({e.name, "_offset"}, 32'(off), 32'(e.offset));
            checkOutput({e.name, "_phase"}, 32'(phase), 32'(e.ph));
        end
    endtask

    // Monitor: any start pulse or rdy rise is an event that must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdy = rdy;
        end else begin
            if ({init_en, ksa_en, prga_en} != 3'b000) handleEvent({init_en, ksa_en, prga_en}, "pulse");
            if (rdy && !prev_rdy) handleEvent(3'b000, "rdy");
            if (rdy && en) acc_cyc = cyc + 1;
            prev_rdy = rdy;
        end
    end

    task automatic waitPhase(input logic [1:0] p, input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (phase == p) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL timeout_%s: phase %0d never seen, expected within %0d cycles", name, p, budget);
        end
    endtask

    task automatic waitRdy(input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (rdy) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL timeout_%s: rdy stayed 0, expected 1 within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        en = 1'b0;
        key = 24'h0;
        init_s_addr = 8'h55; init_s_wrdata = 8'h66; init_s_wren = 1'b1;
        ksa_s_addr  = 8'h33; ksa_s_wrdata  = 8'h44; ksa_s_wren  = 1'b0;
        prga_s_addr = 8'h77; prga_s_wrdata = 8'h88; prga_s_wren = 1'b1;

        // Reset takes effect without a clock edge.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_rdy", 32'(rdy), 32'd1);
        checkOutput("reset_pulses", 32'({init_en, ksa_en, prga_en}), 32'd0);
        checkOutput("reset_phase", 32'(phase), 32'd0);
        checkOutput("reset_key_q", 32'(key_q), 32'd0);
        checkOutput("reset_s_addr", 32'(s_addr), 32'd0);
        checkOutput("reset_s_wrdata", 32'(s_wrdata), 32'd0);
        checkOutput("reset_s_wren", 32'(s_wren), 32'd0);
`ifdef ARC4_SEQ_CYCLE_CNT_EN
        checkOutput("reset_cycles", cycles, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] full run, key 1E4600, busy 256/768/100");
        applyStimulus(24'h1E4600, 256, 768, 100, 0, 257, 1026, 1128);
        checkOutput("key_q_captured", 32'(key_q), 32'h1E4600);
        checkOutput("init_grant_wren", 32'(s_wren), 32'd1);
        checkOutput("init_grant_addr", 32'(s_addr), 32'h55);
        checkOutput("init_grant_data", 32'(s_wrdata), 32'h66);
        waitPhase(2'b10, 400, "ksa_phase");
        checkOutput("ksa_grant_wren", 32'(s_wren), 32'd0);
        checkOutput("ksa_grant_addr", 32'(s_addr), 32'h33);
        checkOutput("ksa_grant_data", 32'(s_wrdata), 32'h44);
        waitPhase(2'b11, 1000, "prga_phase");
        checkOutput("prga_grant_wren", 32'(s_wren), 32'd1);
        checkOutput("prga_grant_addr", 32'(s_addr), 32'h77);
        checkOutput("prga_grant_data", 32'(s_wrdata), 32'h88);
        waitRdy(300, "full_run");
        checkOutput("idle_s_wren", 32'(s_wren), 32'd0);
        checkOutput("idle_s_addr", 32'(s_addr), 32'd0);
        checkOutput("idle_key_q_held", 32'(key_q), 32'h1E4600);
`ifdef ARC4_SEQ_CYCLE_CNT_EN
        checkOutput("cycles_full_run", cycles, 32'd1128);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("cycles_held_idle", cycles, 32'd1128);
`endif

        $display("[TB] en held high across runs");
        busy_i = 4; busy_k = 4; busy_p = 4;
        pushRun(0, 5, 10, 16);
        pushRun(0, 5, 10, 16);
        en = 1'b1;
        waitRdy(100, "held_run_a");
        @(posedge clk);
        #1 en = 1'b0;
        waitRdy(100, "held_run_b");
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] ksa_rdy held low on START_KSA entry");
        ksa_hold = 1'b1;
        applyStimulus(24'h0A0B0C, 4, 6, 4, 0, 11, 18, 24);
        waitPhase(2'b10, 20, "ksa_stall");
        repeat (5) @(posedge clk);
        #1 ksa_hold = 1'b0;
        waitRdy(60, "ksa_stall_run");
`ifdef ARC4_SEQ_CYCLE_CNT_EN
        checkOutput("cycles_stall_run", cycles, 32'd24);
`endif

        $display("[TB] init stub drops rdy two cycles late");
        late_i = 2;
        applyStimulus(24'h123456, 6, 4, 4, 0, 7, 12, 18);
        waitRdy(60, "late_drop_run");
        late_i = 0;

        $display("[TB] reset during WAIT_KSA");
        applyStimulus(24'hABCDEF, 4, 20, 4, 0, 5, -1, -1);
        waitPhase(2'b10, 20, "pre_reset_ksa");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_rdy", 32'(rdy), 32'd1);
        checkOutput("midrun_reset_phase", 32'(phase), 32'd0);
        checkOutput("midrun_reset_pulses", 32'({init_en, ksa_en, prga_en}), 32'd0);
        checkOutput("midrun_reset_key_q", 32'(key_q), 32'd0);
        checkOutput("midrun_reset_s_addr", 32'(s_addr), 32'd0);
`ifdef ARC4_SEQ_CYCLE_CNT_EN
        checkOutput("midrun_reset_cycles", cycles, 32'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        applyStimulus(24'h000102, 4, 4, 4, 0, 5, 10, 16);
        waitRdy(60, "post_reset_run");

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
